// File: rtl/hafsa_leds_arb_pkg.sv
// Shared types and constants for the LED PIO arbiter.
// The optional read-back check is enabled with HAFSA_LEDS_READBACK_EN.
package hafsa_leds_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam logic [1:0] LED_REG_ADDR = 2'd0;
    localparam int         AV_DATA_W    = 32;
    localparam int         MAX_REQ      = 8;

endpackage

// File: rtl/hafsa_sopc_leds_arbiter_rr_picker.sv
// Combinational round-robin picker: scans from last_idx+1 (mod NUM_REQ)
// and returns the first active requester.
import hafsa_leds_arb_pkg::*;

module hafsa_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_idx,
    output logic [2:0]         winner,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         cand;

    assign req_ext = MAX_REQ'(req);

    // last_idx is always below NUM_REQ, so one conditional subtract is a full modulo.
    always_comb begin
        winner = last_idx;
        valid  = 1'b0;
        cand   = 4'd0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_idx} + 4'(off);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!valid && req_ext[cand[2:0]]) begin
                winner = cand[2:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hafsa_sopc_leds_arbiter.sv
// Avalon-MM master sharing one LED PIO between NUM_REQ requesters.
// Define HAFSA_LEDS_READBACK_EN to add a read-back verify cycle and sticky mismatch flag.
import hafsa_leds_arb_pkg::*;

module hafsa_sopc_leds_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [1:0]                m_address,
    output logic                      m_chipselect,
    output logic                      m_write_n,
    output logic [AV_DATA_W-1:0]      m_writedata,
    input  logic [AV_DATA_W-1:0]      m_readdata,
    output logic                      busy,
    output logic [2:0]                grant_idx,
    output logic [15:0]               write_count,
    output logic                      mismatch
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [2:0]        pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] pick_data;
    logic [DATA_W-1:0] data_q;
    logic              req_granted;
    logic              unused_readdata;

    hafsa_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (req),
        .last_idx (grant_idx),
        .winner   (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_data   = '0;
        req_granted = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == pick_idx) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
            if (3'(i) == grant_idx) begin
                req_granted = req[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
`ifdef HAFSA_LEDS_READBACK_EN
                state_nxt = READ;
`else
                state_nxt = ACK;
`endif
            end
            READ: begin
                state_nxt = ACK;
            end
            ACK: begin
                if (!req_granted) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pattern and index are only captured on a grant, so m_writedata holds between transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant_idx   <= 3'(NUM_REQ - 1);
            data_q      <= '0;
            write_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                grant_idx <= pick_idx;
                data_q    <= pick_data;
            end
            if (state_nxt == ACK && state != ACK) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

`ifdef HAFSA_LEDS_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (state == READ && m_readdata[DATA_W-1:0] != data_q) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

    assign unused_readdata = ^m_readdata;

    // Bus and handshake outputs decode straight from state so reset clears them at once.
    always_comb begin
        m_chipselect = (state == WRITE) || (state == READ);
        m_write_n    = (state != WRITE);
        m_address    = LED_REG_ADDR;
        m_writedata  = AV_DATA_W'(data_q);
        busy         = (state != IDLE);
        ack          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state == ACK) && (3'(i) == grant_idx);
        end
    end

endmodule

// File: tb/tb_hafsa_sopc_leds_arbiter.sv
// Directed self-checking bench for hafsa_sopc_leds_arbiter with a write scoreboard
// and a small PIO model; covers HAFSA_LEDS_READBACK_EN when that macro is defined.
module tb_hafsa_sopc_leds_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
`ifdef HAFSA_LEDS_READBACK_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 2;
`endif

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [1:0]                m_address;
    logic                      m_chipselect;
    logic                      m_write_n;
    logic [31:0]               m_writedata;
    logic [31:0]               m_readdata;
    logic                      busy;
    logic [2:0]                grant_idx;
    logic [15:0]               write_count;
    logic                      mismatch;

    logic [7:0] pio_q;
    logic       corrupt_bit3;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t sb[$];
    int      checks = 0;
    int      passes = 0;
    int      fails  = 0;
    int      lat;

    hafsa_sopc_leds_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .write_count  (write_count),
        .mismatch     (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave model; corrupt_bit3 forces bit 3 low on read-back.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_q <= 8'h00;
        end else if (m_chipselect && !m_write_n && m_address == 2'd0) begin
            pio_q <= m_writedata[7:0];
        end
    end
    assign m_readdata = {24'b0, corrupt_bit3 ? (pio_q & 8'hF7) : pio_q};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic push);
        wr_exp_t e;
        req_data[idx*DATA_W +: DATA_W] = data;
        req[idx] = 1'b1;
        if (push) begin
            e.idx  = 3'(idx);
            e.data = data;
            sb.push_back(e);
        end
    endtask

    task automatic waitAck(input int idx, output int n);
        n = 0;
        while (ack[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // Every bus write must match the oldest scoreboard entry.
    always @(negedge clk) begin
        wr_exp_t e;
        if (reset === 1'b0 && m_chipselect === 1'b1) begin
            checkOutput("cs_only_when_busy", 32'(busy), 32'd1);
            checkOutput("bus_addr", 32'(m_address), 32'd0);
            if (m_write_n === 1'b0) begin
                checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("wr_data", m_writedata, {24'b0, e.data});
                    checkOutput("wr_idx", 32'(grant_idx), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        req          = '0;
        req_data     = '0;
        corrupt_bit3 = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_cs", 32'(m_chipselect), 32'd0);
        checkOutput("rst_write_n", 32'(m_write_n), 32'd1);
        checkOutput("rst_wdata", m_writedata, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant", 32'(grant_idx), 32'(NUM_REQ - 1));
        checkOutput("rst_count", 32'(write_count), 32'd0);
        checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] contention with four-phase handshakes");
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(1, 8'h22, 1'b1);
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            while (ack === '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("rr_ack", 32'(ack), 32'd1 << (g % 2));
            req[g % 2] = 1'b0;
            @(negedge clk);
            checkOutput("rr_ack_released", 32'(ack), 32'd0);
            if (g < 2) begin
                applyStimulus(g % 2, (g == 0) ? 8'h33 : 8'h44, 1'b1);
            end
        end
        waitIdle("rr_idle");
        checkOutput("rr_count", 32'(write_count), 32'd4);

        $display("[TB] single request");
        applyStimulus(0, 8'hA5, 1'b1);
        waitAck(0, lat);
        checkOutput("single_latency", 32'(lat), 32'(ACK_LAT));
        checkOutput("single_ack", 32'(ack), 32'd1);
        @(negedge clk);
        checkOutput("single_ack_held", 32'(ack), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("single_ack_low", 32'(ack), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd0);
        checkOutput("single_count", 32'(write_count), 32'd5);

        $display("[TB] abandoned request");
        applyStimulus(0, 8'h3C, 1'b1);
        @(negedge clk);
        applyStimulus(1, 8'h99, 1'b0);
        @(negedge clk);
        req[1] = 1'b0;
        waitAck(0, lat);
        checkOutput("abandon_ack", 32'(ack), 32'd1);
        req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abandon_quiet_ack", 32'(ack), 32'd0);
        end
        checkOutput("abandon_busy", 32'(busy), 32'd0);
        checkOutput("abandon_count", 32'(write_count), 32'd6);

        $display("[TB] request dropped during write");
        applyStimulus(1, 8'h5A, 1'b1);
        @(negedge clk);
        req[1] = 1'b0;
        waitAck(1, lat);
        checkOutput("drop_ack", 32'(ack), 32'd2);
        @(negedge clk);
        checkOutput("drop_ack_one_cycle", 32'(ack), 32'd0);
        checkOutput("drop_busy", 32'(busy), 32'd0);
        checkOutput("drop_count", 32'(write_count), 32'd7);

        $display("[TB] reset during write");
        applyStimulus(0, 8'hC3, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_cs", 32'(m_chipselect), 32'd0);
        checkOutput("midrst_write_n", 32'(m_write_n), 32'd1);
        checkOutput("midrst_ack", 32'(ack), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_grant", 32'(grant_idx), 32'(NUM_REQ - 1));
        checkOutput("midrst_count", 32'(write_count), 32'd0);
        checkOutput("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] write counter wrap");
        force dut.write_count = 16'hFFFF;
        @(negedge clk);
        release dut.write_count;
        @(negedge clk);
        checkOutput("wrap_pre", 32'(write_count), 32'h0000FFFF);
        applyStimulus(1, 8'h81, 1'b1);
        waitAck(1, lat);
        checkOutput("wrap_ack", 32'(ack), 32'd2);
        checkOutput("wrap_count", 32'(write_count), 32'd0);
        req[1] = 1'b0;
        waitIdle("wrap_idle");
        checkOutput("wrap_grant", 32'(grant_idx), 32'd1);

`ifdef HAFSA_LEDS_READBACK_EN
        $display("[TB] read-back mismatch");
        corrupt_bit3 = 1'b1;
        applyStimulus(0, 8'h0F, 1'b1);
        waitAck(0, lat);
        checkOutput("rb_readdata", m_readdata, 32'h07);
        checkOutput("rb_mismatch_set", 32'(mismatch), 32'd1);
        req[0] = 1'b0;
        waitIdle("rb_idle");
        corrupt_bit3 = 1'b0;
        applyStimulus(1, 8'h66, 1'b1);
        waitAck(1, lat);
        req[1] = 1'b0;
        waitIdle("rb_idle2");
        checkOutput("rb_mismatch_sticky", 32'(mismatch), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rb_mismatch_cleared", 32'(mismatch), 32'd0);
`else
        checkOutput("no_readback_mismatch", 32'(mismatch), 32'd0);
`endif

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
